// File: rtl/core4_shared_copy_master.sv
// Avalon-MM master that copies a block of words inside the shared on-chip RAM.
// One word at a time: read, wait out the read latency, write, then advance both pointers.
module core4_shared_copy_master #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LEN_W        = 15,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_src_addr,
    input  logic [ADDR_W-1:0]   i_dst_addr,
    input  logic [LEN_W-1:0]    i_len,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic [LEN_W-1:0]    o_words_done,
    output logic [ADDR_W-1:0]   o_avm_address,
    output logic [DATA_W/8-1:0] o_avm_byteenable,
    output logic                o_avm_chipselect,
    output logic                o_avm_write,
    output logic [DATA_W-1:0]   o_avm_writedata,
    input  logic [DATA_W-1:0]   i_avm_readdata,
    input  logic                i_avm_waitrequest
);

    localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StRd, StRlat, StWr, StDone} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [LEN_W-1:0]    r_remaining;
    logic [LEN_W-1:0]    r_words_done;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [DATA_W-1:0]   r_buf;
    logic                r_abort;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = (i_len == '0) ? StDone : StRd;
                end
            end
            StRd: begin
                if (!i_avm_waitrequest) begin
                    w_state_next = StRlat;
                end
            end
            StRlat: begin
                if (r_lat_cnt == '0) begin
                    w_state_next = StWr;
                end
            end
            StWr: begin
                // Abort only takes effect once the word in flight has been written.
                if (!i_avm_waitrequest) begin
                    w_state_next = (r_remaining == LEN_W'(1) || r_abort) ? StDone : StRd;
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_src        <= '0;
            r_dst        <= '0;
            r_remaining  <= '0;
            r_words_done <= '0;
            r_lat_cnt    <= '0;
            r_buf        <= '0;
            r_abort      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_src        <= i_src_addr;
                        r_dst        <= i_dst_addr;
                        r_remaining  <= i_len;
                        r_words_done <= '0;
                    end
                end
                StRd: begin
                    if (!i_avm_waitrequest) begin
                        r_lat_cnt <= LAT_LOAD;
                    end
                end
                StRlat: begin
                    if (r_lat_cnt == '0) begin
                        r_buf <= i_avm_readdata;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                StWr: begin
                    if (!i_avm_waitrequest) begin
                        r_src        <= r_src + ADDR_W'(1);
                        r_dst        <= r_dst + ADDR_W'(1);
                        r_remaining  <= r_remaining - LEN_W'(1);
                        r_words_done <= r_words_done + LEN_W'(1);
                    end
                end
                default: ;
            endcase

            if (r_state == StDone) begin
                r_abort <= 1'b0;
            end else if (r_state != StIdle && i_abort) begin
                r_abort <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only, so no input reaches the bus combinationally.
    always_comb begin
        o_busy           = (r_state != StIdle);
        o_done           = 1'b0;
        o_words_done     = r_words_done;
        o_avm_address    = '0;
        o_avm_chipselect = 1'b0;
        o_avm_write      = 1'b0;
        o_avm_writedata  = '0;
        unique case (r_state)
            StRd: begin
                o_avm_chipselect = 1'b1;
                o_avm_address    = r_src;
            end
            StWr: begin
                o_avm_chipselect = 1'b1;
                o_avm_write      = 1'b1;
                o_avm_address    = r_dst;
                o_avm_writedata  = r_buf;
            end
            StDone: o_done = 1'b1;
            default: ;
        endcase
        o_avm_byteenable = o_avm_chipselect ? '1 : '0;
    end

endmodule
